// File: rtl/data_io_pkg.sv
// data_io_pkg: command codes, FSM states and CRC-16/CCITT helper for data_io_wide
package data_io_pkg;
    localparam logic [7:0] UIO_FILE_TX     = 8'h53;
    localparam logic [7:0] UIO_FILE_TX_DAT = 8'h54;
    localparam logic [7:0] UIO_FILE_INDEX  = 8'h55;
    localparam logic [15:0] CRC_POLY = 16'h1021;
    localparam logic [15:0] CRC_INIT = 16'hFFFF;

    typedef enum logic {CMD, PAYLOAD} state_t;

    function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] d);
        logic [15:0] r;
        r = c ^ {d, 8'h00};
        for (int i = 0; i < 8; i++) r = r[15] ? {r[14:0], 1'b0} ^ CRC_POLY : {r[14:0], 1'b0};
        return r;
    endfunction
endpackage

// File: rtl/data_io_spi_rx.sv
// data_io_spi_rx: oversampled SPI receiver; byte_valid pulses with rx_byte, is_cmd marks the first byte of a frame.
module data_io_spi_rx (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       sck,
    input  logic       ss,
    input  logic       sdi,
    output logic       byte_valid,
    output logic       is_cmd,
    output logic       idle,
    output logic [7:0] rx_byte
);
    logic [2:0] sck_s;
    logic [1:0] ss_s, sdi_s;
    logic [3:0] cnt;
    logic [6:0] sr;
    logic       rise;

    assign rise = sck_s[1] & ~sck_s[2];
    assign idle = ss_s[1];

    // cnt runs 0..7 for the command byte, then cycles 8..15 for payload bytes
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sck_s      <= '0;
            ss_s       <= 2'b11;
            sdi_s      <= '0;
            cnt        <= '0;
            sr         <= '0;
            byte_valid <= 1'b0;
            is_cmd     <= 1'b0;
            rx_byte    <= '0;
        end else begin
            sck_s      <= {sck_s[1:0], sck};
            ss_s       <= {ss_s[0], ss};
            sdi_s      <= {sdi_s[0], sdi};
            byte_valid <= 1'b0;
            if (ss_s[1]) cnt <= '0;
            else if (rise) begin
                sr  <= {sr[5:0], sdi_s[1]};
                cnt <= (cnt[2:0] == 3'd7) ? 4'd8 : cnt + 4'd1;
                if (cnt[2:0] == 3'd7) begin
                    byte_valid <= 1'b1;
                    is_cmd     <= ~cnt[3];
                    rx_byte    <= {sr, sdi_s[1]};
                end
            end
        end
    end
endmodule

// File: rtl/data_io_wide.sv
// data_io_wide: SPI file download into an external RAM over a req/ack write port.
// Define DATA_IO_CRC_EN to add a CRC-16/CCITT output over the downloaded bytes.
module data_io_wide #(
    parameter int                ADDR_W     = 16,
    parameter int                DW         = 8,
    parameter logic [ADDR_W-1:0] START_ADDR = '0,
    parameter int                SIZE_W     = 24
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              sck,
    input  logic              ss,
    input  logic              sdi,
    output logic              downloading,
    output logic [7:0]        file_index,
    output logic [SIZE_W-1:0] size,
    output logic              overrun,
    output logic              wr_req,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DW-1:0]     wr_data,
    input  logic              wr_ack
`ifdef DATA_IO_CRC_EN
    ,
    output logic [15:0]       crc
`endif
);
    import data_io_pkg::*;

    logic              byte_valid, is_cmd, idle;
    logic [7:0]        rx_byte, cmd;
    state_t            state, state_nx;
    logic              pv, start, stop, dat, idx, ack, form, reload, ending;
    logic [DW-1:0]     word;
    logic [ADDR_W-1:0] addr_nx;

    data_io_spi_rx u_rx (
        .clk       (clk),
        .reset_n   (reset_n),
        .sck       (sck),
        .ss        (ss),
        .sdi       (sdi),
        .byte_valid(byte_valid),
        .is_cmd    (is_cmd),
        .idle      (idle),
        .rx_byte   (rx_byte)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= CMD;
        else state <= state_nx;
    end

    always_comb begin
        state_nx = idle ? CMD : (byte_valid && is_cmd) ? PAYLOAD : state;
        pv       = state == PAYLOAD && byte_valid && !is_cmd;
        start    = pv && cmd == UIO_FILE_TX && rx_byte[0];
        stop     = pv && cmd == UIO_FILE_TX && !rx_byte[0] && downloading;
        dat      = pv && cmd == UIO_FILE_TX_DAT && downloading;
        idx      = pv && cmd == UIO_FILE_INDEX;
        ack      = wr_req && wr_ack;
        addr_nx  = reload ? START_ADDR : wr_addr + ADDR_W'(1);
    end

    generate
        if (DW == 16) begin : g16
            logic [7:0] half;
            logic       half_valid;
            // low byte waits here; end of download flushes it with a zero upper byte
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    half       <= '0;
                    half_valid <= 1'b0;
                end else if (start || stop) half_valid <= 1'b0;
                else if (dat) begin
                    half_valid <= ~half_valid;
                    half       <= rx_byte;
                end
            end
            assign form = half_valid && (dat || stop);
            assign word = {dat ? rx_byte : 8'h00, half};
        end else begin : g8
            assign form = dat;
            assign word = rx_byte;
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cmd         <= '0;
            file_index  <= '0;
            downloading <= 1'b0;
            ending      <= 1'b0;
            size        <= '0;
            overrun     <= 1'b0;
            wr_req      <= 1'b0;
            wr_addr     <= START_ADDR;
            wr_data     <= '0;
            reload      <= 1'b0;
        end else begin
            if (byte_valid && is_cmd) cmd <= rx_byte;
            if (idx) file_index <= rx_byte;
            if (start) begin
                downloading <= 1'b1;
                ending      <= 1'b0;
                size        <= '0;
                overrun     <= 1'b0;
            end else if (stop) ending <= 1'b1;
            else if (ending && !wr_req && !form) begin
                downloading <= 1'b0;
                ending      <= 1'b0;
            end
            if (dat && ~&size) size <= size + SIZE_W'(1);
            if (form && (!wr_req || ack)) begin
                wr_req  <= 1'b1;
                wr_data <= word;
                if (ack) wr_addr <= addr_nx;
            end else if (form) overrun <= 1'b1;
            else if (ack) begin
                wr_req  <= 1'b0;
                wr_addr <= addr_nx;
            end
            // a restart during a pending write reloads the address once that write is acked
            if (start) reload <= wr_req && !ack;
            else if (ack) reload <= 1'b0;
            if (start && !(wr_req && !ack)) wr_addr <= START_ADDR;
        end
    end

`ifdef DATA_IO_CRC_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) crc <= CRC_INIT;
        else if (start) crc <= CRC_INIT;
        else if (dat) crc <= crc16_byte(crc, rx_byte);
    end
`endif
endmodule

// File: tb/tb_data_io_wide.sv
// tb_data_io_wide: directed checks of three data_io_wide builds (8-bit, 16-bit, 4-bit address) sharing one SPI stream.
module tb_data_io_wide;
    logic clk = 0, reset_n = 0, sck = 0, ss = 1, sdi = 0;
    logic ack_a = 1, ack_b = 1, ack_c = 1;
    logic dl_a, dl_b, dl_c, ov_a, ov_b, ov_c, rq_a, rq_b, rq_c;
    logic [7:0] fi_a, fi_b, fi_c, dt_a, dt_c;
    logic [15:0] dt_b, ad_a, ad_b;
    logic [3:0] ad_c;
    logic [23:0] sz_a, sz_b, sz_c;
`ifdef DATA_IO_CRC_EN
    logic [15:0] crc_a, crc_b, crc_c;
`endif
    logic [31:0] la [128], lb [128], lc [128];
    int na = 0, nb = 0, nc = 0, ba, bb, bc;
    int n_cmp = 0, n_err = 0;

    always #5 clk = ~clk;

    data_io_wide #(.ADDR_W(16), .DW(8), .START_ADDR(16'h0100), .SIZE_W(24)) dut_a (
        .clk(clk), .reset_n(reset_n), .sck(sck), .ss(ss), .sdi(sdi),
        .downloading(dl_a), .file_index(fi_a), .size(sz_a), .overrun(ov_a),
        .wr_req(rq_a), .wr_addr(ad_a), .wr_data(dt_a), .wr_ack(ack_a)
`ifdef DATA_IO_CRC_EN
        , .crc(crc_a)
`endif
    );
    data_io_wide #(.ADDR_W(16), .DW(16), .START_ADDR(16'h0000), .SIZE_W(24)) dut_b (
        .clk(clk), .reset_n(reset_n), .sck(sck), .ss(ss), .sdi(sdi),
        .downloading(dl_b), .file_index(fi_b), .size(sz_b), .overrun(ov_b),
        .wr_req(rq_b), .wr_addr(ad_b), .wr_data(dt_b), .wr_ack(ack_b)
`ifdef DATA_IO_CRC_EN
        , .crc(crc_b)
`endif
    );
    data_io_wide #(.ADDR_W(4), .DW(8), .START_ADDR(4'h0), .SIZE_W(24)) dut_c (
        .clk(clk), .reset_n(reset_n), .sck(sck), .ss(ss), .sdi(sdi),
        .downloading(dl_c), .file_index(fi_c), .size(sz_c), .overrun(ov_c),
        .wr_req(rq_c), .wr_addr(ad_c), .wr_data(dt_c), .wr_ack(ack_c)
`ifdef DATA_IO_CRC_EN
        , .crc(crc_c)
`endif
    );

    always @(posedge clk) begin
        if (rq_a && ack_a) begin la[na] <= {ad_a, 8'h00, dt_a}; na <= na + 1; end
        if (rq_b && ack_b) begin lb[nb] <= {ad_b, dt_b}; nb <= nb + 1; end
        if (rq_c && ack_c) begin lc[nc] <= {12'h000, ad_c, 8'h00, dt_c}; nc <= nc + 1; end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic bits(input logic [7:0] b, input int n);
        for (int i = 7; i > 7 - n; i--) begin
            sdi = b[i];
            #40 sck = 1;
            #40 sck = 0;
        end
    endtask

    task automatic frame_end();
        #80 ss = 1;
        #400;
        repeat (2) @(negedge clk);
    endtask

    task automatic cmd1(input logic [7:0] c, input logic [7:0] d);
        ss = 0;
        #80;
        bits(c, 8);
        bits(d, 8);
        frame_end();
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_dl", dl_a, 0);
        chk("rst_req", rq_a, 0);
        chk("rst_addr_a", ad_a, 16'h0100);
        chk("rst_addr_b", ad_b, 0);
        chk("rst_size", sz_a, 0);
        chk("rst_ovr", ov_a, 0);
        chk("rst_data", dt_a, 0);
        reset_n = 1;
        repeat (3) @(negedge clk);

        // 8-bit and 16-bit downloads of A0..A3 with ack tied high
        ba = na; bb = nb;
        cmd1(8'h53, 8'h01);
        chk("p1_dl_on", dl_a, 1);
        ss = 0; #80;
        bits(8'h54, 8); bits(8'hA0, 8); bits(8'hA1, 8); bits(8'hA2, 8); bits(8'hA3, 8);
        frame_end();
        cmd1(8'h53, 8'h00);
        chk("p1_nwr", na - ba, 4);
        chk("p1_w0", la[ba], {16'h0100, 16'h00A0});
        chk("p1_w1", la[ba+1], {16'h0101, 16'h00A1});
        chk("p1_w2", la[ba+2], {16'h0102, 16'h00A2});
        chk("p1_w3", la[ba+3], {16'h0103, 16'h00A3});
        chk("p1_size", sz_a, 4);
        chk("p1_dl_off", dl_a, 0);
        chk("p1_addr", ad_a, 16'h0104);
        chk("p1_b_nwr", nb - bb, 2);
        chk("p1_b_w1", lb[bb+1], {16'h0001, 16'hA3A2});

        // 16-bit odd-length download with flush
        bb = nb;
        cmd1(8'h53, 8'h01);
        ss = 0; #80;
        bits(8'h54, 8); bits(8'h11, 8); bits(8'h22, 8); bits(8'h33, 8);
        frame_end();
        cmd1(8'h53, 8'h00);
        chk("p2_nwr", nb - bb, 2);
        chk("p2_w0", lb[bb], {16'h0000, 16'h2211});
        chk("p2_w1", lb[bb+1], {16'h0001, 16'h0033});
        chk("p2_size", sz_b, 3);
        chk("p2_dl_off", dl_b, 0);

        // ack withheld over three bytes: first held, later ones dropped
        ack_a = 0;
        ba = na;
        cmd1(8'h53, 8'h01);
        ss = 0; #80;
        bits(8'h54, 8); bits(8'hB0, 8); bits(8'hB1, 8); bits(8'hB2, 8);
        frame_end();
        chk("p3_req", rq_a, 1);
        chk("p3_hold_addr", ad_a, 16'h0100);
        chk("p3_hold_data", dt_a, 8'hB0);
        chk("p3_ovr", ov_a, 1);
        chk("p3_size", sz_a, 3);
        ack_a = 1;
        repeat (5) @(negedge clk);
        chk("p3_nwr", na - ba, 1);
        chk("p3_w0", la[ba], {16'h0100, 16'h00B0});
        chk("p3_addr", ad_a, 16'h0101);
        chk("p3_req_off", rq_a, 0);

        // file index, restart, aborted partial byte
        ba = na;
        cmd1(8'h55, 8'h07);
        cmd1(8'h53, 8'h01);
        ss = 0; #80;
        bits(8'h54, 8); bits(8'hFF, 5);
        frame_end();
        chk("p4_index", fi_a, 8'h07);
        chk("p4_nwr0", na - ba, 0);
        chk("p4_size0", sz_a, 0);
        chk("p4_ovr_clr", ov_a, 0);
        cmd1(8'h54, 8'hC5);
        chk("p4_nwr1", na - ba, 1);
        chk("p4_w0", la[ba], {16'h0100, 16'h00C5});
        chk("p4_size1", sz_a, 1);

        // 4-bit address wrap over 18 bytes
        bc = nc;
        cmd1(8'h53, 8'h01);
        ss = 0; #80;
        bits(8'h54, 8);
        for (int i = 0; i < 18; i++) bits(8'(i), 8);
        frame_end();
        cmd1(8'h53, 8'h00);
        chk("p5_nwr", nc - bc, 18);
        chk("p5_w15", lc[bc+15], {16'h000F, 16'h000F});
        chk("p5_w16", lc[bc+16], {16'h0000, 16'h0010});
        chk("p5_w17", lc[bc+17], {16'h0001, 16'h0011});
        chk("p5_addr", {28'h0, ad_c}, 2);
        chk("p5_size", sz_c, 18);

        // reset_n mid-transfer with a write pending
        ack_a = 0;
        cmd1(8'h53, 8'h01);
        ss = 0; #80;
        bits(8'h54, 8); bits(8'h5A, 8); bits(8'h5B, 3);
        @(negedge clk);
        chk("p6_pre_req", rq_a, 1);
        reset_n = 0;
        @(negedge clk);
        chk("p6_dl", dl_a, 0);
        chk("p6_req", rq_a, 0);
        chk("p6_addr", ad_a, 16'h0100);
        chk("p6_data", dt_a, 0);
        chk("p6_size", sz_a, 0);
        chk("p6_ovr", ov_a, 0);
        chk("p6_index", fi_a, 0);
`ifdef DATA_IO_CRC_EN
        chk("p6_crc", crc_a, 16'hFFFF);
`endif
        ss = 1;
        repeat (5) @(negedge clk);
        reset_n = 1;
        ack_a = 1;
        repeat (5) @(negedge clk);

        // "123456789"
        cmd1(8'h53, 8'h01);
        ss = 0; #80;
        bits(8'h54, 8);
        for (int i = 0; i < 9; i++) bits(8'h31 + 8'(i), 8);
        frame_end();
        cmd1(8'h53, 8'h00);
        chk("p7_size", sz_a, 9);
        chk("p7_dl_off", dl_a, 0);
`ifdef DATA_IO_CRC_EN
        chk("p7_crc", crc_a, 16'h29B1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
